// File: rtl/mem_port_arbiter.sv
// Shares a single 64-bit memory port between the fetch unit and the load/store unit.
// Only one transaction is in flight; simultaneous requests alternate round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_reg;
  logic                owner_reg;
  logic                last_owner_reg;
  logic                mem_req_valid_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   wmask_reg;

  logic                grant_ifu;
  logic                grant_lsu;
  logic                resp_fire;

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && state_reg == IDLE) begin
      if (ifu_req_valid && (!lsu_req_valid || last_owner_reg == OWN_LSU)) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      owner_reg         <= OWN_IFU;
      last_owner_reg    <= OWN_LSU;
      mem_req_valid_reg <= 1'b0;
      addr_reg          <= '0;
      wen_reg           <= 1'b0;
      wdata_reg         <= '0;
      wmask_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_ifu) begin
            owner_reg         <= OWN_IFU;
            last_owner_reg    <= OWN_IFU;
            addr_reg          <= ifu_addr;
            wen_reg           <= 1'b0;
            wdata_reg         <= '0;
            wmask_reg         <= '0;
            mem_req_valid_reg <= 1'b1;
            state_reg         <= REQ;
          end else if (grant_lsu) begin
            owner_reg         <= OWN_LSU;
            last_owner_reg    <= OWN_LSU;
            addr_reg          <= lsu_addr;
            wen_reg           <= lsu_wen;
            wdata_reg         <= lsu_wdata;
            wmask_reg         <= lsu_wmask;
            mem_req_valid_reg <= 1'b1;
            state_reg         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
            state_reg         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          mem_req_valid_reg <= 1'b0;
          state_reg         <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_reg;
  assign mem_addr      = {addr_reg[ADDR_W-1:3], 3'b000};
  assign mem_wen       = wen_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wmask     = wmask_reg;

  // Response data is passed straight through to the owner and zero elsewhere.
  assign resp_fire      = !rst && (state_reg == WAIT) && mem_resp_valid;
  assign ifu_resp_valid = resp_fire && (owner_reg == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (owner_reg == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected grants, memory
// requests and responses into queues; independent monitors pop and compare.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk;
  logic          rst;
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mem_exp_t;

  typedef struct {
    bit            lsu;
    logic [DW-1:0] data;
    bit            chk;
  } resp_exp_t;

  bit        exp_grant[$];
  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_mem(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
    mem_exp_t e;
    e.addr = a; e.wen = w; e.wdata = d; e.wmask = m;
    exp_mem.push_back(e);
  endtask

  task automatic push_resp(input bit l, input logic [DW-1:0] d, input bit c);
    resp_exp_t r;
    r.lsu = l; r.data = d; r.chk = c;
    exp_resp.push_back(r);
  endtask

  // ---------------- monitors ----------------
  bit        g_exp;
  mem_exp_t  m_exp;
  resp_exp_t r_exp;

  always @(negedge clk) begin
    if (!rst && (ifu_req_ready || lsu_req_ready)) begin
      check64("grant_onehot", 64'(ifu_req_ready && lsu_req_ready), 64'd0);
      if (exp_grant.size() == 0) begin
        check64("grant_unexpected", 64'(lsu_req_ready), 64'(ifu_req_ready));
        compared++; mismatched++;
        $display("FAIL grant_unexpected: ifu_ready=%0b lsu_ready=%0b, expected no grant",
                 ifu_req_ready, lsu_req_ready);
      end else begin
        g_exp = exp_grant.pop_front();
        check64("grant_owner", 64'(lsu_req_ready), 64'(g_exp));
        $display("grant to %s", lsu_req_ready ? "LSU" : "IFU");
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (exp_mem.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL mem_unexpected: request addr %h accepted, expected none", mem_addr);
      end else begin
        m_exp = exp_mem.pop_front();
        check64("mem_addr", mem_addr, m_exp.addr);
        check64("mem_wen", 64'(mem_wen), 64'(m_exp.wen));
        check64("mem_wdata", mem_wdata, m_exp.wdata);
        check64("mem_wmask", 64'(mem_wmask), 64'(m_exp.wmask));
        $display("mem req addr=%h wen=%0b wdata=%h wmask=%h", mem_addr, mem_wen, mem_wdata, mem_wmask);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
        check64("resp_onehot", 64'(ifu_resp_valid && lsu_resp_valid), 64'd0);
        if (exp_resp.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL resp_unexpected: ifu_resp=%0b lsu_resp=%0b, expected none",
                   ifu_resp_valid, lsu_resp_valid);
        end else begin
          r_exp = exp_resp.pop_front();
          check64("resp_owner", 64'(lsu_resp_valid), 64'(r_exp.lsu));
          if (r_exp.chk)
            check64("resp_data", r_exp.lsu ? lsu_rdata : ifu_rdata, r_exp.data);
          $display("resp to %s data=%h", lsu_resp_valid ? "LSU" : "IFU",
                   lsu_resp_valid ? lsu_rdata : ifu_rdata);
        end
      end
      if (!ifu_resp_valid) check64("ifu_rdata_idle", ifu_rdata, 64'd0);
      if (!lsu_resp_valid) check64("lsu_rdata_idle", lsu_rdata, 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant(input bit lsu_side);
    int n = 0;
    @(negedge clk);
    while (!(lsu_side ? lsu_req_ready : ifu_req_ready) && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    check64("grant_seen", 64'(lsu_side ? lsu_req_ready : ifu_req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Called at the start of the cycle after the grant; returns at the start of
  // the cycle following the response.
  task automatic mem_serve(input int stall, input int delay, input logic [DW-1:0] rdata);
    int n = 0;
    mem_exp_t e;
    e.addr = '0; e.wen = 1'b0; e.wdata = '0; e.wmask = '0;
    if (exp_mem.size() > 0) e = exp_mem[0];
    mem_req_ready = (stall == 0);
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    check64("mem_req_seen", 64'(mem_req_valid), 64'd1);
    if (!mem_req_valid) begin
      mem_req_ready = 1'b0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) mem_req_ready = 1'b1;
      @(negedge clk);
      check64("stall_valid", 64'(mem_req_valid), 64'd1);
      check64("stall_addr", mem_addr, e.addr);
      check64("stall_wen", 64'(mem_wen), 64'(e.wen));
      check64("stall_wdata", mem_wdata, e.wdata);
      check64("stall_wmask", 64'(mem_wmask), 64'(e.wmask));
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check64("wait_ifu_ready", 64'(ifu_req_ready), 64'd0);
      check64("wait_lsu_ready", 64'(lsu_req_ready), 64'd0);
      check64("wait_mem_valid", 64'(mem_req_valid), 64'd0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0004;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset state, with an IFU request already pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check64("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check64("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
    check64("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
    check64("rst_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    check64("rst_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    check64("rst_ifu_rdata", ifu_rdata, 64'd0);
    check64("rst_lsu_rdata", lsu_rdata, 64'd0);
    check64("rst_mem_addr", mem_addr, 64'd0);

    // Test 1: IFU fetch at minimum latency
    exp_grant.push_back(1'b0);
    push_mem(64'h8000_0000, 1'b0, 64'd0, 8'h00);
    push_resp(1'b0, 64'h1111_2222_3333_4444, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check64("t1_ifu_ready_c0", 64'(ifu_req_ready), 64'd1);
    check64("t1_lsu_ready_c0", 64'(lsu_req_ready), 64'd0);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check64("t1_mem_valid_c1", 64'(mem_req_valid), 64'd1);
    check64("t1_mem_addr_c1", mem_addr, 64'h8000_0000);
    check64("t1_mem_wen_c1", 64'(mem_wen), 64'd0);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    check64("t1_ifu_resp_c2", 64'(ifu_resp_valid), 64'd1);
    check64("t1_ifu_rdata_c2", ifu_rdata, 64'h1111_2222_3333_4444);
    check64("t1_lsu_resp_c2", 64'(lsu_resp_valid), 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_rdata = '0;

    // Test 2: both valid right after reset -> IFU, LSU, IFU
    do_reset();
    ifu_addr = 64'h0000_0000_0000_100C;
    lsu_addr = 64'h0000_0000_0000_2025; lsu_wen = 1'b0;
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
    push_mem(64'h1008, 1'b0, 64'd0, 8'h00);
    push_mem(64'h2020, 1'b0, 64'd0, 8'h00);
    push_mem(64'h1008, 1'b0, 64'd0, 8'h00);
    push_resp(1'b0, 64'hA0A0_0000_0000_0001, 1'b1);
    push_resp(1'b1, 64'hB0B0_0000_0000_0002, 1'b1);
    push_resp(1'b0, 64'hC0C0_0000_0000_0003, 1'b1);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    wait_grant(1'b0);
    mem_serve(0, 0, 64'hA0A0_0000_0000_0001);
    wait_grant(1'b1);
    mem_serve(0, 0, 64'hB0B0_0000_0000_0002);
    wait_grant(1'b0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_serve(0, 0, 64'hC0C0_0000_0000_0003);

    // Test 3: LSU write with a 4-cycle memory stall
    exp_grant.push_back(1'b1);
    push_mem(64'h8000_0010, 1'b1, 64'hDEAD_BEEF, 8'h0F);
    push_resp(1'b1, 64'd0, 1'b0);
    lsu_addr = 64'h8000_0010; lsu_wen = 1'b1; lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    lsu_req_valid = 1'b1;
    wait_grant(1'b1);
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0; lsu_addr = '0;
    mem_serve(4, 0, 64'h5555_5555_5555_5555);

    // Test 4: spurious responses in IDLE and in REQ
    mem_resp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    check64("spur_idle_ifu", 64'(ifu_resp_valid), 64'd0);
    check64("spur_idle_lsu", 64'(lsu_resp_valid), 64'd0);
    check64("spur_idle_memv", 64'(mem_req_valid), 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_rdata = '0;
    exp_grant.push_back(1'b0);
    push_mem(64'h4000_0040, 1'b0, 64'd0, 8'h00);
    push_resp(1'b0, 64'hD0D0_D0D0_0000_0004, 1'b1);
    ifu_addr = 64'h4000_0047; ifu_req_valid = 1'b1;
    wait_grant(1'b0);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clk);
    check64("spur_req_ifu", 64'(ifu_resp_valid), 64'd0);
    check64("spur_req_lsu", 64'(lsu_resp_valid), 64'd0);
    check64("spur_req_memv", 64'(mem_req_valid), 64'd1);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check64("spur_req_hold", 64'(mem_req_valid), 64'd1);
    @(posedge clk); #1;
    mem_serve(0, 0, 64'hD0D0_D0D0_0000_0004);

    // Test 5: asynchronous reset in WAIT, late response ignored
    exp_grant.push_back(1'b1);
    push_mem(64'h0000_3000, 1'b0, 64'd0, 8'h00);
    lsu_addr = 64'h0000_3000; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    mem_req_ready = 1'b1;
    wait_grant(1'b1);
    lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check64("rstw_mem_valid", 64'(mem_req_valid), 64'd0);
    check64("rstw_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    check64("rstw_mem_addr", mem_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hBAD2_BAD2_BAD2_BAD2;
    @(negedge clk);
    check64("late_ifu_resp", 64'(ifu_resp_valid), 64'd0);
    check64("late_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_rdata = '0;
    exp_grant.push_back(1'b0);
    push_mem(64'h0000_5008, 1'b0, 64'd0, 8'h00);
    push_resp(1'b0, 64'hE0E0_E0E0_0000_0005, 1'b1);
    ifu_addr = 64'h0000_500C; ifu_req_valid = 1'b1;
    wait_grant(1'b0);
    ifu_req_valid = 1'b0;
    mem_serve(0, 0, 64'hE0E0_E0E0_0000_0005);

    // Test 6: 5-cycle response delay while both requesters hold valid
    exp_grant.push_back(1'b1);
    push_mem(64'h6000_0018, 1'b0, 64'd0, 8'h00);
    push_resp(1'b1, 64'hF0F0_F0F0_0000_0006, 1'b1);
    lsu_addr = 64'h6000_0018; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    wait_grant(1'b1);
    ifu_req_valid = 1'b1; ifu_addr = 64'h7000_0000;
    lsu_addr = 64'h9999_9998;
    exp_grant.push_back(1'b0);
    push_mem(64'h7000_0000, 1'b0, 64'd0, 8'h00);
    push_resp(1'b0, 64'h0707_0707_0000_0007, 1'b1);
    mem_serve(0, 5, 64'hF0F0_F0F0_0000_0006);
    wait_grant(1'b0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_serve(0, 0, 64'h0707_0707_0000_0007);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check64("left_grants", 64'(exp_grant.size()), 64'd0);
    check64("left_mem", 64'(exp_mem.size()), 64'd0);
    check64("left_resp", 64'(exp_resp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "time limit");
  end

endmodule
